// File: rtl/sm_display_pkg.sv
// Shared types and constants for the seven-segment display encoder.
// State encoding, glyph constants and the BCD adjust step.
package sm_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_ENCODE
    } state_t;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [15:0] DEC_LIMIT = 16'd9999;

    // One double-dabble correction: add 3 to every nibble that is >= 5.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_hex_to_seg.sv
// Combinational 4-bit to 7-segment glyph decoder.
// Bit order {g,f,e,d,c,b,a}, active-high.
module sm_hex_to_seg (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Map each nibble to its hex glyph.
    always_comb begin
        seg = 7'h00;
        unique case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/sm_display_encoder.sv
// Captures a 16-bit value and renders it as four segment patterns.
// Decimal mode converts to BCD with a 16-cycle double-dabble.
module sm_display_encoder
    import sm_display_pkg::*;
#(
    parameter bit BLANK_LEADING  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clkIn,
    input  logic        rst_n,
    input  logic [15:0] value_i,
    input  logic        dec_i,
    input  logic        load_i,
    output logic        busy_o,
    output logic        ovf_o,
    output logic [6:0]  digit1,
    output logic [6:0]  digit2,
    output logic [6:0]  digit3,
    output logic [6:0]  digit4
);

    localparam logic [6:0] INV = {7{SEG_ACTIVE_LOW}};

    state_t      state;
    state_t      state_nxt;
    logic [15:0] bin_q;
    logic [15:0] bcd_q;
    logic        dec_q;
    logic        ovf_pend_q;
    logic [4:0]  iter_q;
    logic        take;

    logic [15:0] src;
    logic [6:0]  raw  [4];
    logic [6:0]  enc  [4];
    logic [3:0]  lead;

    assign take = (state == ST_IDLE) && load_i;

    // State register.
    always_ff @(posedge clkIn) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (load_i) begin
                    if (dec_i && (value_i <= DEC_LIMIT))
                        state_nxt = ST_CONVERT;
                    else
                        state_nxt = ST_ENCODE;
                end
            end
            ST_CONVERT: begin
                if (iter_q == 5'd15)
                    state_nxt = ST_ENCODE;
            end
            ST_ENCODE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Busy whenever a load is being processed.
    always_comb begin
        busy_o = (state != ST_IDLE);
    end

    // Capture the load, then shift-and-adjust once per CONVERT cycle.
    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            dec_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            iter_q     <= '0;
        end else if (take) begin
            bin_q      <= value_i;
            bcd_q      <= '0;
            dec_q      <= dec_i;
            ovf_pend_q <= dec_i && (value_i > DEC_LIMIT);
            iter_q     <= '0;
        end else if (state == ST_CONVERT) begin
            {bcd_q, bin_q} <= {bcd_adjust(bcd_q), bin_q} << 1;
            iter_q         <= iter_q + 5'd1;
        end
    end

    assign src = dec_q ? bcd_q : bin_q;

    for (genvar i = 0; i < 4; i++) begin : g_seg
        sm_hex_to_seg u_seg (
            .nib (src[4*i +: 4]),
            .seg (raw[i])
        );
    end

    // Apply overflow dashes, leading-zero blanking, then polarity.
    always_comb begin
        lead    = 4'b0000;
        lead[3] = BLANK_LEADING && (src[15:12] == 4'h0);
        lead[2] = lead[3] && (src[11:8] == 4'h0);
        lead[1] = lead[2] && (src[7:4] == 4'h0);
        for (int i = 0; i < 4; i++) begin
            if (ovf_pend_q)
                enc[i] = SEG_DASH ^ INV;
            else if (lead[i])
                enc[i] = SEG_BLANK ^ INV;
            else
                enc[i] = raw[i] ^ INV;
        end
    end

    // Digit and overflow registers change only at the end of ENCODE.
    always_ff @(posedge clkIn) begin
        if (!rst_n) begin
            digit1 <= SEG_BLANK ^ INV;
            digit2 <= SEG_BLANK ^ INV;
            digit3 <= SEG_BLANK ^ INV;
            digit4 <= SEG_BLANK ^ INV;
            ovf_o  <= 1'b0;
        end else if (state == ST_ENCODE) begin
            digit1 <= enc[0];
            digit2 <= enc[1];
            digit3 <= enc[2];
            digit4 <= enc[3];
            ovf_o  <= ovf_pend_q;
        end
    end

endmodule

// File: tb/tb_sm_display_encoder.sv
// Directed self-checking bench for sm_display_encoder.
// Three instances share stimulus: default, no blanking, active-low.
module tb_sm_display_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        dec;
    logic        load;

    logic        busy, ovf;
    logic [6:0]  d1, d2, d3, d4;
    logic        nb_busy, nb_ovf;
    logic [6:0]  nb1, nb2, nb3, nb4;
    logic        al_busy, al_ovf;
    logic [6:0]  al1, al2, al3, al4;

    int checks = 0;
    int errors = 0;
    int cyc;

    sm_display_encoder dut (
        .clkIn(clk), .rst_n(rst_n), .value_i(value), .dec_i(dec),
        .load_i(load), .busy_o(busy), .ovf_o(ovf),
        .digit1(d1), .digit2(d2), .digit3(d3), .digit4(d4)
    );

    sm_display_encoder #(.BLANK_LEADING(1'b0)) dut_nb (
        .clkIn(clk), .rst_n(rst_n), .value_i(value), .dec_i(dec),
        .load_i(load), .busy_o(nb_busy), .ovf_o(nb_ovf),
        .digit1(nb1), .digit2(nb2), .digit3(nb3), .digit4(nb4)
    );

    sm_display_encoder #(.SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clkIn(clk), .rst_n(rst_n), .value_i(value), .dec_i(dec),
        .load_i(load), .busy_o(al_busy), .ovf_o(al_ovf),
        .digit1(al1), .digit2(al2), .digit3(al3), .digit4(al4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse load for one cycle; returns at the negedge of cycle N+1.
    task automatic do_load(input logic [15:0] v, input logic d);
        @(negedge clk);
        value = v;
        dec   = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Count busy cycles from N+1 until idle, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        value = '0;
        dec   = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({d4, d3, d2, d1} !== 28'h0) begin
            errors++;
            $display("FAIL reset_digits got %h want %h", {d4, d3, d2, d1}, 28'h0);
        end
        checks++;
        if ({busy, ovf} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got %b want 00", {busy, ovf});
        end
        checks++;
        if ({al4, al3, al2, al1} !== {4{7'h7F}}) begin
            errors++;
            $display("FAIL reset_active_low got %h want %h",
                     {al4, al3, al2, al1}, {4{7'h7F}});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_hex;
        do_load(16'hBEEF, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hex_busy_n1 got %b want 1", busy);
        end
        wait_idle(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL hex_busy_cycles got %0d want 1", cyc);
        end
        checks++;
        if ({d4, d3, d2, d1} !== {7'h7C, 7'h79, 7'h79, 7'h71}) begin
            errors++;
            $display("FAIL hex_beef got %h want %h", {d4, d3, d2, d1},
                     {7'h7C, 7'h79, 7'h79, 7'h71});
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL hex_ovf got %b want 0", ovf);
        end
        checks++;
        if ({al4, al1} !== {7'h03, 7'h0E}) begin
            errors++;
            $display("FAIL hex_active_low got %h want %h", {al4, al1},
                     {7'h03, 7'h0E});
        end
    endtask

    task automatic test_decimal;
        do_load(16'd1234, 1'b1);
        repeat (15) @(negedge clk);
        checks++;
        if ({d4, d3, d2, d1} !== {7'h7C, 7'h79, 7'h79, 7'h71}) begin
            errors++;
            $display("FAIL dec_hold_n16 got %h want %h", {d4, d3, d2, d1},
                     {7'h7C, 7'h79, 7'h79, 7'h71});
        end
        wait_idle(cyc);
        cyc = cyc + 15;
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL dec_busy_cycles got %0d want 17", cyc);
        end
        checks++;
        if ({d4, d3, d2, d1} !== {7'h06, 7'h5B, 7'h4F, 7'h66}) begin
            errors++;
            $display("FAIL dec_1234 got %h want %h", {d4, d3, d2, d1},
                     {7'h06, 7'h5B, 7'h4F, 7'h66});
        end
        do_load(16'd9999, 1'b1);
        wait_idle(cyc);
        checks++;
        if ({d4, d3, d2, d1} !== {4{7'h6F}} || ovf !== 1'b0) begin
            errors++;
            $display("FAIL dec_9999 got %h/%b want %h/0", {d4, d3, d2, d1},
                     ovf, {4{7'h6F}});
        end
    endtask

    task automatic test_blanking;
        do_load(16'd7, 1'b1);
        wait_idle(cyc);
        checks++;
        if ({d4, d3, d2, d1} !== {7'h00, 7'h00, 7'h00, 7'h07}) begin
            errors++;
            $display("FAIL blank_dec7 got %h want %h", {d4, d3, d2, d1},
                     {7'h00, 7'h00, 7'h00, 7'h07});
        end
        checks++;
        if ({nb4, nb3, nb2, nb1} !== {7'h3F, 7'h3F, 7'h3F, 7'h07}) begin
            errors++;
            $display("FAIL noblank_dec7 got %h want %h", {nb4, nb3, nb2, nb1},
                     {7'h3F, 7'h3F, 7'h3F, 7'h07});
        end
        do_load(16'h0000, 1'b0);
        wait_idle(cyc);
        checks++;
        if ({d4, d3, d2, d1} !== {7'h00, 7'h00, 7'h00, 7'h3F}) begin
            errors++;
            $display("FAIL blank_hex0 got %h want %h", {d4, d3, d2, d1},
                     {7'h00, 7'h00, 7'h00, 7'h3F});
        end
        do_load(16'h0100, 1'b0);
        wait_idle(cyc);
        checks++;
        if ({nb4, nb3, nb2, nb1} !== {7'h3F, 7'h06, 7'h3F, 7'h3F}) begin
            errors++;
            $display("FAIL noblank_0100 got %h want %h", {nb4, nb3, nb2, nb1},
                     {7'h3F, 7'h06, 7'h3F, 7'h3F});
        end
        checks++;
        if ({d4, d3, d2, d1} !== {7'h00, 7'h06, 7'h3F, 7'h3F}) begin
            errors++;
            $display("FAIL blank_0100 got %h want %h", {d4, d3, d2, d1},
                     {7'h00, 7'h06, 7'h3F, 7'h3F});
        end
    endtask

    task automatic test_overflow;
        do_load(16'd10000, 1'b1);
        wait_idle(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL ovf_busy_cycles got %0d want 1", cyc);
        end
        checks++;
        if ({d4, d3, d2, d1} !== {4{7'h40}} || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_dash got %h/%b want %h/1", {d4, d3, d2, d1},
                     ovf, {4{7'h40}});
        end
        checks++;
        if ({nb4, nb1} !== {7'h40, 7'h40}) begin
            errors++;
            $display("FAIL ovf_noblank got %h want %h", {nb4, nb1},
                     {7'h40, 7'h40});
        end
        do_load(16'h0001, 1'b0);
        wait_idle(cyc);
        checks++;
        if ({d4, d3, d2, d1} !== {7'h00, 7'h00, 7'h00, 7'h06} || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %h/%b want %h/0", {d4, d3, d2, d1},
                     ovf, {7'h00, 7'h00, 7'h00, 7'h06});
        end
    endtask

    task automatic test_back_to_back;
        do_load(16'd1234, 1'b1);
        repeat (3) @(negedge clk);
        value = 16'd5678;
        dec   = 1'b1;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_idle(cyc);
        cyc = cyc + 4;
        checks++;
        if (cyc != 17) begin
            errors++;
            $display("FAIL ignore_busy_cycles got %0d want 17", cyc);
        end
        checks++;
        if ({d4, d3, d2, d1} !== {7'h06, 7'h5B, 7'h4F, 7'h66}) begin
            errors++;
            $display("FAIL ignore_result got %h want %h", {d4, d3, d2, d1},
                     {7'h06, 7'h5B, 7'h4F, 7'h66});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_queue got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        do_load(16'd9999, 1'b1);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({d4, d3, d2, d1} !== 28'h0 || {busy, ovf} !== 2'b00) begin
            errors++;
            $display("FAIL midreset got %h/%b want 0/00", {d4, d3, d2, d1},
                     {busy, ovf});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got %b want 0", busy);
        end
        do_load(16'd42, 1'b1);
        wait_idle(cyc);
        checks++;
        if ({d4, d3, d2, d1} !== {7'h00, 7'h00, 7'h66, 7'h5B}) begin
            errors++;
            $display("FAIL after_reset_42 got %h want %h", {d4, d3, d2, d1},
                     {7'h00, 7'h00, 7'h66, 7'h5B});
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_blanking();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
